pkt_cache_ctrl: RTL and testbench

PKT_CACHE_CTRL -- requirements
Module: pkt_cache_ctrl

---
 rtl/pkt_cache_ctrl_pkg.sv | 21 ++
 rtl/pkt_cache_ctrl_if.sv | 41 ++++
 rtl/pkt_cache_ctrl_ram.sv | 38 +++
 rtl/pkt_cache_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pkt_cache_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_cache_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the packet cache controller.
package pkt_cache_ctrl_pkg;

    localparam int DATA_W    = 134;
    localparam int ADDR_W    = 11;
    localparam int BUF_WORDS = 128;
    localparam int OFF_W     = 7;

    // Packet word type codes carried in bits [133:132]
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] MID  = 2'b11;
    localparam logic [1:0] TAIL = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_DONE} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN, R_DONE} rstate_e;

    function automatic logic is_tail(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: 2] == TAIL;
    endfunction

endpackage

// File: rtl/pkt_cache_ctrl_if.sv
// Bus bundle between the packet cache controller and its neighbours.
//
// Handshake rules: every *_wr signal is a single-cycle strobe sampled on the
// rising clock edge. in_pkt_data_wr may only be asserted while out_pkt_ready=1.
// Output strobes (out_valid_wr, out_pkt_data_wr, out_ram2addr_valid) carry no
// backpressure: the receiver must accept them in the cycle they are high.
interface pkt_cache_ctrl_if;
    import pkt_cache_ctrl_pkg::*;

    logic [DATA_W-1:0] in_pkt_data;
    logic              in_pkt_data_wr;
    logic              in_pkt_valid;
    logic              in_pkt_valid_wr;
    logic              out_pkt_ready;
    logic [ADDR_W-1:0] in_waddr;
    logic              in_waddr_wr;
    logic              out_valid;
    logic              out_valid_wr;
    logic [ADDR_W-1:0] in_raddr;
    logic              in_raddr_wr;
    logic              out_ram2addr_valid;
    logic [DATA_W-1:0] out_pkt_data;
    logic              out_pkt_data_wr;
    wstate_e           dbg_wstate;
    rstate_e           dbg_rstate;

    modport slave (
        input  in_pkt_data, in_pkt_data_wr, in_pkt_valid, in_pkt_valid_wr,
        input  in_waddr, in_waddr_wr, in_raddr, in_raddr_wr,
        output out_pkt_ready, out_valid, out_valid_wr, out_ram2addr_valid,
        output out_pkt_data, out_pkt_data_wr, dbg_wstate, dbg_rstate
    );

    modport master (
        output in_pkt_data, in_pkt_data_wr, in_pkt_valid, in_pkt_valid_wr,
        output in_waddr, in_waddr_wr, in_raddr, in_raddr_wr,
        input  out_pkt_ready, out_valid, out_valid_wr, out_ram2addr_valid,
        input  out_pkt_data, out_pkt_data_wr, dbg_wstate, dbg_rstate
    );

endinterface

// File: rtl/pkt_cache_ctrl_ram.sv
// Simple dual-port 134x2048 RAM with a registered (1-cycle) read port.
module ram_134_2048
    import pkt_cache_ctrl_pkg::*;
#(
    parameter PLATFORM = "xilinx"
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    generate
        if (PLATFORM == "xilinx") begin : g_xilinx
            (* ram_style = "block" *) logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
            logic [DATA_W-1:0] rdata_q;
            // Block RAM write port and registered read port
            always_ff @(posedge clk) begin
                if (we) mem[waddr] <= wdata;
                if (re) rdata_q <= mem[raddr];
            end
            assign rdata = rdata_q;
        end else begin : g_generic
            logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
            logic [DATA_W-1:0] rdata_q;
            // Generic inferred RAM with registered read
            always_ff @(posedge clk) begin
                if (we) mem[waddr] <= wdata;
                if (re) rdata_q <= mem[raddr];
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/pkt_cache_ctrl.sv
// Packet cache controller: stores incoming packets into 128-word buffers and
// streams stored packets back out, with independent write and read engines.
module pkt_cache_ctrl
    import pkt_cache_ctrl_pkg::*;
#(
    parameter PLATFORM = "xilinx"
) (
    input logic clk,
    input logic rst,
    pkt_cache_ctrl_if.slave bus
);

    // ---------------- write engine ----------------
    wstate_e           wstate_q, wstate_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d;
    logic [OFF_W-1:0]  woff_q, woff_d;
    logic              wfull_q, wfull_d;      // offset 127 already stored
    logic              trunc_q, trunc_d;
    logic              vld_seen_q, vld_seen_d;
    logic              vld_q, vld_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // Write FSM next-state, buffer write staging and completion outputs
    always_comb begin
        wstate_d          = wstate_q;
        wbase_d           = wbase_q;
        woff_d            = woff_q;
        wfull_d           = wfull_q;
        trunc_d           = trunc_q;
        vld_seen_d        = vld_seen_q;
        vld_d             = vld_q;
        ram_we_d          = 1'b0;
        ram_waddr_d       = ram_waddr_q;
        ram_wdata_d       = ram_wdata_q;
        bus.out_pkt_ready = 1'b0;
        bus.out_valid     = 1'b0;
        bus.out_valid_wr  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (bus.in_waddr_wr) begin
                    wbase_d    = bus.in_waddr;
                    woff_d     = '0;
                    wfull_d    = 1'b0;
                    trunc_d    = 1'b0;
                    vld_seen_d = 1'b0;
                    vld_d      = 1'b0;
                    wstate_d   = W_DATA;
                end
            end
            W_DATA: begin
                bus.out_pkt_ready = 1'b1;
                if (bus.in_pkt_valid_wr) begin
                    vld_seen_d = 1'b1;
                    vld_d      = bus.in_pkt_valid;
                end
                if (bus.in_pkt_data_wr) begin
                    // Once the last slot is used, remaining words are dropped
                    if (!wfull_q) begin
                        ram_we_d    = 1'b1;
                        ram_waddr_d = wbase_q + {{(ADDR_W-OFF_W){1'b0}}, woff_q};
                        ram_wdata_d = bus.in_pkt_data;
                        if (woff_q == OFF_W'(BUF_WORDS-1)) begin
                            ram_wdata_d[DATA_W-1 -: 2] = TAIL;
                            wfull_d = 1'b1;
                            if (!is_tail(bus.in_pkt_data)) trunc_d = 1'b1;
                        end
                        woff_d = woff_q + 1'b1;
                    end
                    if (is_tail(bus.in_pkt_data))
                        wstate_d = (vld_seen_q || bus.in_pkt_valid_wr) ? W_DONE : W_WAIT;
                end
            end
            W_WAIT: begin
                if (bus.in_pkt_valid_wr) begin
                    vld_d    = bus.in_pkt_valid;
                    wstate_d = W_DONE;
                end
            end
            W_DONE: begin
                bus.out_valid_wr = 1'b1;
                bus.out_valid    = vld_q & ~trunc_q;
                wstate_d         = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write engine registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q    <= W_IDLE;
            wbase_q     <= '0;
            woff_q      <= '0;
            wfull_q     <= 1'b0;
            trunc_q     <= 1'b0;
            vld_seen_q  <= 1'b0;
            vld_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            wstate_q    <= wstate_d;
            wbase_q     <= wbase_d;
            woff_q      <= woff_d;
            wfull_q     <= wfull_d;
            trunc_q     <= trunc_d;
            vld_seen_q  <= vld_seen_d;
            vld_q       <= vld_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // ---------------- read engine ----------------
    rstate_e           rstate_q, rstate_d;
    logic [ADDR_W-1:0] rbase_q, rbase_d;
    logic [OFF_W-1:0]  roff_q, roff_d;
    logic              rd_pend_q, rd_pend_d;  // a read was issued last cycle
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_wr_q, out_wr_d;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Read FSM: one read per cycle until the tail returns; the read issued
    // alongside the tail's return is discarded in R_DRAIN.
    always_comb begin
        rstate_d               = rstate_q;
        rbase_d                = rbase_q;
        roff_d                 = roff_q;
        rd_pend_d              = 1'b0;
        out_data_d             = out_data_q;
        out_wr_d               = 1'b0;
        rd_en                  = 1'b0;
        rd_addr                = rbase_q + {{(ADDR_W-OFF_W){1'b0}}, roff_q};
        bus.out_ram2addr_valid = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (bus.in_raddr_wr) begin
                    rbase_d  = bus.in_raddr;
                    roff_d   = '0;
                    rstate_d = R_READ;
                end
            end
            R_READ: begin
                rd_en     = 1'b1;
                rd_pend_d = 1'b1;
                roff_d    = roff_q + 1'b1;
                if (rd_pend_q) begin
                    out_wr_d   = 1'b1;
                    out_data_d = rd_data;
                    if (is_tail(rd_data)) rstate_d = R_DRAIN;
                end
            end
            R_DRAIN: rstate_d = R_DONE;
            R_DONE: begin
                bus.out_ram2addr_valid = 1'b1;
                rstate_d               = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read engine registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q   <= R_IDLE;
            rbase_q    <= '0;
            roff_q     <= '0;
            rd_pend_q  <= 1'b0;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            rstate_q   <= rstate_d;
            rbase_q    <= rbase_d;
            roff_q     <= roff_d;
            rd_pend_q  <= rd_pend_d;
            out_data_q <= out_data_d;
            out_wr_q   <= out_wr_d;
        end
    end

    assign bus.out_pkt_data    = out_data_q;
    assign bus.out_pkt_data_wr = out_wr_q;
    assign bus.dbg_wstate      = wstate_q;
    assign bus.dbg_rstate      = rstate_q;

    ram_134_2048 #(.PLATFORM(PLATFORM)) u_ram (
        .clk   (clk),
        .we    (ram_we_q),
        .waddr (ram_waddr_q),
        .wdata (ram_wdata_q),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_pkt_cache_ctrl.sv
// Self-checking bench for pkt_cache_ctrl: random packets against a buffer model.
module tb_pkt_cache_ctrl;
    import pkt_cache_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    pkt_cache_ctrl_if bus ();

    pkt_cache_ctrl #(.PLATFORM("xilinx")) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int fails     = 0;

    // Reference buffer contents, filled from the storage rules
    logic [DATA_W-1:0] model_mem [0:2047];

    // ---------------- output monitor (samples on falling edge) ----------------
    logic [DATA_W-1:0] rd_words[$];
    int                rd_cycles[$];
    int                r2a_cycles[$];
    logic              vw_vals[$];
    int                vw_cycles[$];

    always @(negedge clk) begin
        if (bus.out_pkt_data_wr === 1'b1) begin
            rd_words.push_back(bus.out_pkt_data);
            rd_cycles.push_back(cyc);
        end
        if (bus.out_ram2addr_valid === 1'b1) r2a_cycles.push_back(cyc);
        if (bus.out_valid_wr === 1'b1) begin
            vw_vals.push_back(bus.out_valid);
            vw_cycles.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mk_word(input logic [1:0] code);
        logic [3:0] pad;
        pad = 4'($urandom_range(0, 15));
        return {code, pad, $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // vmode: <0 disposition with first word, 0 with tail word, >0 that many cycles after tail
    task automatic write_pkt(input logic [ADDR_W-1:0] base, input int len,
                             input logic vld, input int vmode, input string name);
        logic [DATA_W-1:0] w;
        logic [1:0]        code;
        logic              exp_v;
        int                exp_t;
        vw_vals.delete();
        vw_cycles.delete();
        bus.in_waddr    = base;
        bus.in_waddr_wr = 1'b1;
        tick();
        bus.in_waddr_wr = 1'b0;
        tests_run++;
        if (bus.out_pkt_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_after_base: got %b exp 1", name, bus.out_pkt_ready);
        end
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            code = (i == len - 1) ? TAIL : ((i == 0) ? HEAD : MID);
            w = mk_word(code);
            if (i < BUF_WORDS) begin
                model_mem[{base[10:7], 7'(i)}] = (i == BUF_WORDS - 1) ? {TAIL, w[DATA_W-3:0]} : w;
            end
            bus.in_pkt_data    = w;
            bus.in_pkt_data_wr = 1'b1;
            if ((vmode == 0 && i == len - 1) || (vmode < 0 && i == 0)) begin
                bus.in_pkt_valid_wr = 1'b1;
                bus.in_pkt_valid    = vld;
            end
            if (i == 1) begin
                // base strobe mid-packet must have no effect
                bus.in_waddr    = base ^ 11'h400;
                bus.in_waddr_wr = 1'b1;
            end
            tick();
            bus.in_pkt_data_wr  = 1'b0;
            bus.in_pkt_valid_wr = 1'b0;
            bus.in_waddr_wr     = 1'b0;
        end
        exp_t = cyc;
        if (vmode > 0) begin
            for (int k = 0; k < vmode; k++) begin
                tests_run++;
                if (bus.out_pkt_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s ready_while_wait[%0d]: got %b exp 0", name, k, bus.out_pkt_ready);
                end
                tick();
            end
            bus.in_pkt_valid_wr = 1'b1;
            bus.in_pkt_valid    = vld;
            tick();
            bus.in_pkt_valid_wr = 1'b0;
            exp_t = cyc;
        end
        tick();
        tick();
        exp_v = vld && (len <= BUF_WORDS);
        tests_run++;
        if (vw_cycles.size() != 1 || vw_cycles[0] != exp_t || vw_vals[0] !== exp_v) begin
            fails++;
            $display("FAIL %s completion: got %0d pulses first @%0d val %b, exp 1 pulse @%0d val %b",
                     name, vw_cycles.size(), (vw_cycles.size() > 0) ? vw_cycles[0] : -1,
                     (vw_vals.size() > 0) ? vw_vals[0] : 1'bx, exp_t, exp_v);
        end
    endtask

    task automatic read_pkt(input logic [ADDR_W-1:0] base, input string name);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] w;
        int t0, n, bad;
        for (int i = 0; i < BUF_WORDS; i++) begin
            w = model_mem[{base[10:7], 7'(i)}];
            exp_q.push_back(w);
            if (w[DATA_W-1 -: 2] == TAIL) break;
        end
        rd_words.delete();
        rd_cycles.delete();
        r2a_cycles.delete();
        bus.in_raddr    = base;
        bus.in_raddr_wr = 1'b1;
        tick();
        bus.in_raddr_wr = 1'b0;
        t0 = cyc;
        n  = 0;
        while (r2a_cycles.size() == 0 && n < 400) begin
            // address strobe while busy must be ignored
            bus.in_raddr    = base ^ 11'h400;
            bus.in_raddr_wr = (n == 1);
            tick();
            n++;
        end
        bus.in_raddr_wr = 1'b0;
        repeat (5) tick();
        tests_run++;
        if (n >= 400) begin
            fails++;
            $display("FAIL %s read_timeout: no ram2addr pulse within %0d cycles", name, n);
        end
        tests_run++;
        if (rd_words.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s read_count: got %0d words exp %0d", name, rd_words.size(), exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < rd_words.size(); i++)
            if (bad < 0 && (rd_words[i] !== exp_q[i] || rd_cycles[i] != t0 + 2 + i)) bad = i;
        tests_run++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s read_word[%0d]: got %h @%0d exp %h @%0d", name, bad,
                     rd_words[bad], rd_cycles[bad], exp_q[bad], t0 + 2 + bad);
        end
        tests_run++;
        if (r2a_cycles.size() != 1 || r2a_cycles[0] != t0 + 2 + exp_q.size()) begin
            fails++;
            $display("FAIL %s ram2addr: got %0d pulses first @%0d exp 1 pulse @%0d", name,
                     r2a_cycles.size(), (r2a_cycles.size() > 0) ? r2a_cycles[0] : -1,
                     t0 + 2 + exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({bus.out_pkt_ready, bus.out_valid, bus.out_valid_wr, bus.out_ram2addr_valid,
             bus.out_pkt_data_wr} !== 5'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b exp 00000", {bus.out_pkt_ready, bus.out_valid,
                     bus.out_valid_wr, bus.out_ram2addr_valid, bus.out_pkt_data_wr});
        end
        tests_run++;
        if (bus.out_pkt_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h exp 0", bus.out_pkt_data);
        end
        tests_run++;
        if (bus.dbg_wstate !== W_IDLE || bus.dbg_rstate !== R_IDLE) begin
            fails++;
            $display("FAIL reset_states: got w=%0d r=%0d exp 0/0", bus.dbg_wstate, bus.dbg_rstate);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (bus.out_pkt_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_ready: got %b exp 0", bus.out_pkt_ready);
        end
    endtask

    task automatic test_basic();
        write_pkt(11'h080, 4, 1'b1, 0, "basic_wr");
        read_pkt(11'h080, "basic_rd");
    endtask

    task automatic test_valid_late();
        write_pkt(11'h200, 4, 1'b0, 5, "late_wr");
        read_pkt(11'h200, "late_rd");
    endtask

    task automatic test_overflow();
        write_pkt(11'h780, 130, 1'b1, 0, "ovf_wr");
        read_pkt(11'h780, "ovf_rd");
        tests_run++;
        if (rd_words.size() != BUF_WORDS || rd_words[BUF_WORDS-1][DATA_W-1 -: 2] !== TAIL) begin
            fails++;
            $display("FAIL ovf_last_code: got %0d words, exp %0d ending in tail code",
                     rd_words.size(), BUF_WORDS);
        end
    endtask

    task automatic test_concurrent();
        fork
            write_pkt(11'h100, 10, 1'b1, -1, "conc_wr");
            read_pkt(11'h080, "conc_rd");
        join
        read_pkt(11'h100, "conc_rd_back");
    endtask

    task automatic test_reset_mid_xfer();
        // write aborted by reset
        vw_cycles.delete();
        vw_vals.delete();
        bus.in_waddr    = 11'h380;
        bus.in_waddr_wr = 1'b1;
        tick();
        bus.in_waddr_wr    = 1'b0;
        bus.in_pkt_data    = mk_word(HEAD);
        bus.in_pkt_data_wr = 1'b1;
        tick();
        bus.in_pkt_data    = mk_word(MID);
        tick();
        bus.in_pkt_data_wr = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.out_pkt_ready !== 1'b0 || bus.dbg_wstate !== W_IDLE) begin
            fails++;
            $display("FAIL rst_wr: got ready=%b w=%0d exp 0/0", bus.out_pkt_ready, bus.dbg_wstate);
        end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        tests_run++;
        if (vw_cycles.size() != 0) begin
            fails++;
            $display("FAIL rst_wr_completion: got %0d pulses exp 0", vw_cycles.size());
        end
        // read aborted by reset while the second word is on the output
        write_pkt(11'h300, 8, 1'b1, 0, "rst_rd_prep");
        rd_words.delete();
        rd_cycles.delete();
        r2a_cycles.delete();
        bus.in_raddr    = 11'h300;
        bus.in_raddr_wr = 1'b1;
        tick();
        bus.in_raddr_wr = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (bus.out_pkt_data_wr !== 1'b1) begin
            fails++;
            $display("FAIL rst_rd_pre: got wr=%b exp 1", bus.out_pkt_data_wr);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.out_pkt_data_wr !== 1'b0 || bus.out_pkt_data !== '0 || bus.dbg_rstate !== R_IDLE) begin
            fails++;
            $display("FAIL rst_rd: got wr=%b data=%h r=%0d exp 0/0/0", bus.out_pkt_data_wr,
                     bus.out_pkt_data, bus.dbg_rstate);
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        tests_run++;
        if (r2a_cycles.size() != 0 || rd_words.size() != 1) begin
            fails++;
            $display("FAIL rst_rd_after: got %0d pulses %0d words exp 0 pulses 1 word",
                     r2a_cycles.size(), rd_words.size());
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] base;
        int len, vmode, sel;
        logic vld;
        for (int p = 0; p < 8; p++) begin
            base  = {4'($urandom_range(3, 14)), 7'd0};
            len   = ($urandom_range(0, 4) == 0) ? $urandom_range(126, 135) : $urandom_range(1, 20);
            vld   = 1'($urandom_range(0, 1));
            sel   = $urandom_range(0, 3);
            vmode = (sel == 0) ? 0 : ((sel == 1) ? -1 : $urandom_range(1, 4));
            write_pkt(base, len, vld, vmode, $sformatf("rnd%0d_wr", p));
            read_pkt(base, $sformatf("rnd%0d_rd", p));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.in_pkt_data     = '0;
        bus.in_pkt_data_wr  = 1'b0;
        bus.in_pkt_valid    = 1'b0;
        bus.in_pkt_valid_wr = 1'b0;
        bus.in_waddr        = '0;
        bus.in_waddr_wr     = 1'b0;
        bus.in_raddr        = '0;
        bus.in_raddr_wr     = 1'b0;
        test_reset();
        test_basic();
        test_valid_late();
        test_overflow();
        test_concurrent();
        test_reset_mid_xfer();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: bench did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
